// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the reaction-time test sequencer.
//   state_t    : sequencer states (IDLE, WAIT, LIT, DONE)
//   LFSR_TAPS  : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   RT_W       : width of the reaction-time result / counter
//   DELAY_W    : width of the random-delay countdown
//   lfsr_step  : one right-shift Galois LFSR step
// -----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          RT_W      = 14;
    localparam int          DELAY_W   = 17;

    // Right-shift Galois form: the bit shifted out of bit 0 is folded back
    // into the tap positions.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/reaction_ctrl_ms_prescaler.sv
// -----------------------------------------------------------------------------
// ms_prescaler
// Divides clk down to a one-cycle millisecond tick.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   clr  : restart the count from 0 on the next edge
//   tick : high during the last cycle of each TICKS_PER_MS period
// After clr the first tick is sampled exactly TICKS_PER_MS edges later.
// -----------------------------------------------------------------------------
module ms_prescaler #(
    parameter int TICKS_PER_MS = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICKS_PER_MS);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICKS_PER_MS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_ctrl
// Reaction-time test sequencer. A start press begins a pseudo-random wait,
// after which the LED is lit and whole milliseconds are counted until the
// response press. Reports the time, an early press, or a timeout.
//   clk          : system clock
//   rst          : asynchronous, active-high reset
//   start_p      : one-cycle debounced start pulse
//   hit_p        : one-cycle debounced response pulse
//   bright       : LED enable to the PWM driver
//   reaction_ms  : last result in ms, held until the next result
//   result_valid : one-cycle pulse when a new result/flag is latched
//   too_early    : last attempt was pressed before the LED lit
//   timed_out    : last attempt reached TIMEOUT_MS
//   busy         : high while waiting or lit
// -----------------------------------------------------------------------------
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int          TICKS_PER_MS = 100000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          TIMEOUT_MS   = 9999
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_p,
    input  logic            hit_p,
    output logic            bright,
    output logic [RT_W-1:0] reaction_ms,
    output logic            result_valid,
    output logic            too_early,
    output logic            timed_out,
    output logic            busy
);

    state_t             state;
    logic [15:0]        lfsr;
    logic [DELAY_W-1:0] delay_cnt;
    logic [RT_W-1:0]    rt_cnt;
    logic               tick;
    logic               clr;

    // Restart the millisecond grid on entry to WAIT and to LIT so the first
    // tick of each phase lands exactly one full period after entry.
    // NOTE: every combinational output gets a default first so no path can
    // infer a latch.
    always_comb begin
        clr = 1'b0;
        case (state)
            IDLE, DONE: clr = start_p;
            WAIT:       clr = tick && !hit_p && (delay_cnt == DELAY_W'(1));
            default:    clr = 1'b0;
        endcase
    end

    ms_prescaler #(
        .TICKS_PER_MS(TICKS_PER_MS)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            delay_cnt    <= '0;
            rt_cnt       <= '0;
            bright       <= 1'b0;
            reaction_ms  <= '0;
            result_valid <= 1'b0;
            too_early    <= 1'b0;
            timed_out    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Free-running so the sampled delay depends on player timing.
            lfsr         <= lfsr_step(lfsr);
            result_valid <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    // hit_p is ignored here; only a start press matters.
                    if (start_p) begin
                        state     <= WAIT;
                        delay_cnt <= DELAY_W'(MIN_DELAY_MS)
                                   + DELAY_W'(lfsr[RAND_BITS-1:0]);
                        too_early <= 1'b0;
                        timed_out <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                WAIT: begin
                    // A hit wins over the expiry tick and over start_p.
                    if (hit_p) begin
                        state        <= DONE;
                        too_early    <= 1'b1;
                        reaction_ms  <= '0;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                    end else if (tick) begin
                        if (delay_cnt == DELAY_W'(1)) begin
                            state  <= LIT;
                            bright <= 1'b1;
                            rt_cnt <= '0;
                        end
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end

                LIT: begin
                    if (hit_p) begin
                        // Pre-increment value: whole milliseconds elapsed.
                        state        <= DONE;
                        reaction_ms  <= rt_cnt;
                        bright       <= 1'b0;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                    end else if (tick) begin
                        if (rt_cnt == RT_W'(TIMEOUT_MS - 1)) begin
                            state        <= DONE;
                            timed_out    <= 1'b1;
                            reaction_ms  <= RT_W'(TIMEOUT_MS);
                            bright       <= 1'b0;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                        end
                        rt_cnt <= rt_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reaction_ctrl
// Self-checking bench for reaction_ctrl with a small timing configuration.
// Each attempt is scored from the timing rules: a press at edge d (counted
// from the edge that samples start_p) is early if d <= delay*TICKS, a
// reaction of (d - delay*TICKS - 1) / TICKS ms if within the timeout window,
// otherwise the attempt times out TIMEOUT*TICKS edges after the LED lights.
// -----------------------------------------------------------------------------
module tb_reaction_ctrl;

    localparam int          TICKS   = 10;
    localparam int          MIN_MS  = 2;
    localparam int          RBITS   = 2;
    localparam int          TMO_MS  = 50;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          LIMIT   = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_p = 1'b0;
    logic        hit_p = 1'b0;
    logic        bright;
    logic [13:0] reaction_ms;
    logic        result_valid;
    logic        too_early;
    logic        timed_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_prev_ms = 0;

    logic [15:0] m_lfsr;

    reaction_ctrl #(
        .TICKS_PER_MS (TICKS),
        .MIN_DELAY_MS (MIN_MS),
        .RAND_BITS    (RBITS),
        .LFSR_SEED    (SEED),
        .TIMEOUT_MS   (TMO_MS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_p      (start_p),
        .hit_p        (hit_p),
        .bright       (bright),
        .reaction_ms  (reaction_ms),
        .result_valid (result_valid),
        .too_early    (too_early),
        .timed_out    (timed_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference pseudo-random sequence: polynomial x^16+x^14+x^13+x^11+1,
    // stepped once per clock from the seed.
    function automatic logic [15:0] ref_next(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr = SEED;
        else     m_lfsr = ref_next(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_p = 1'b0;
        hit_p = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_prev_ms = 0;
        check("rst_bright", 32'(bright), 0);
        check("rst_reaction_ms", 32'(reaction_ms), 0);
        check("rst_result_valid", 32'(result_valid), 0);
        check("rst_too_early", 32'(too_early), 0);
        check("rst_timed_out", 32'(timed_out), 0);
        check("rst_busy", 32'(busy), 0);
    endtask

    // One full attempt. d: edge (from the start-sampling edge) at which hit_p
    // is sampled; s1/s2: edges at which an extra start_p is sampled (0 = none).
    task automatic run_attempt(input string tag, input int d, input int s1, input int s2);
        int dt, k, kb, bright_err, busy_err, exp_k, exp_ms, exp_kb, rv_extra;
        logic exp_te, exp_to, got;
        dt = (MIN_MS + int'(m_lfsr[RBITS-1:0])) * TICKS;
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 1);
        check({tag, "_too_early_cleared"}, 32'(too_early), 0);
        check({tag, "_timed_out_cleared"}, 32'(timed_out), 0);
        check({tag, "_ms_held"}, 32'(reaction_ms), 32'(exp_prev_ms));

        k = 0; kb = -1; bright_err = 0; busy_err = 0; got = 1'b0;
        while (k < LIMIT) begin
            if (result_valid) begin
                got = 1'b1;
                break;
            end
            if (bright && kb < 0) kb = k;
            if (bright !== (k >= dt)) bright_err++;
            if (busy !== 1'b1) busy_err++;
            hit_p   = (k + 1 == d);
            start_p = (k + 1 == s1) || (k + 1 == s2);
            @(negedge clk);
            k++;
        end
        hit_p = 1'b0;
        start_p = 1'b0;

        if (d <= dt) begin
            exp_k = d; exp_ms = 0; exp_te = 1'b1; exp_to = 1'b0; exp_kb = -1;
        end else if (d <= dt + TMO_MS * TICKS) begin
            exp_k = d; exp_ms = (d - dt - 1) / TICKS; exp_te = 1'b0; exp_to = 1'b0; exp_kb = dt;
        end else begin
            exp_k = dt + TMO_MS * TICKS; exp_ms = TMO_MS; exp_te = 1'b0; exp_to = 1'b1; exp_kb = dt;
        end

        check({tag, "_result_seen"}, 32'(got), 1);
        check({tag, "_result_edge"}, 32'(k), 32'(exp_k));
        check({tag, "_bright_rise_edge"}, 32'(kb), 32'(exp_kb));
        check({tag, "_bright_profile_errs"}, 32'(bright_err), 0);
        check({tag, "_busy_profile_errs"}, 32'(busy_err), 0);
        check({tag, "_reaction_ms"}, 32'(reaction_ms), 32'(exp_ms));
        check({tag, "_too_early"}, 32'(too_early), 32'(exp_te));
        check({tag, "_timed_out"}, 32'(timed_out), 32'(exp_to));
        check({tag, "_bright_off"}, 32'(bright), 0);
        check({tag, "_busy_off"}, 32'(busy), 0);

        rv_extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (result_valid || busy) rv_extra++;
        end
        check({tag, "_single_pulse_and_hold"}, 32'(rv_extra), 0);
        check({tag, "_ms_hold"}, 32'(reaction_ms), 32'(exp_ms));
        exp_prev_ms = exp_ms;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dt, k;
        do_reset();

        // Latency to bright and a 237-cycle reaction.
        dt = (MIN_MS + int'(m_lfsr[RBITS-1:0])) * TICKS;
        run_attempt("lit_hit_237", dt + 237, 0, 0);

        // Early press 5 cycles after start, then a press on the expiry edge.
        run_attempt("early_5", 5, 0, 0);
        dt = (MIN_MS + int'(m_lfsr[RBITS-1:0])) * TICKS;
        run_attempt("early_on_expiry", dt, 0, 0);

        // No response: timeout.
        run_attempt("timeout", 100000, 0, 0);

        // Press on the final lit edge still beats the timeout.
        dt = (MIN_MS + int'(m_lfsr[RBITS-1:0])) * TICKS;
        run_attempt("hit_last_edge", dt + TMO_MS * TICKS, 0, 0);

        // start_p ignored in WAIT; start_p+hit_p together in LIT acts as hit.
        dt = (MIN_MS + int'(m_lfsr[RBITS-1:0])) * TICKS;
        run_attempt("ignored_starts", dt + 85, 3, dt + 85);

        // Reset in the middle of LIT.
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        k = 0;
        while (!bright && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        check("midlit_reached_lit", 32'(bright), 1);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midlit_async_bright", 32'(bright), 0);
        check("midlit_async_busy", 32'(busy), 0);
        check("midlit_async_reaction_ms", 32'(reaction_ms), 0);
        check("midlit_async_too_early", 32'(too_early), 0);
        check("midlit_async_timed_out", 32'(timed_out), 0);
        check("midlit_async_result_valid", 32'(result_valid), 0);
        do_reset();
        dt = (MIN_MS + int'(m_lfsr[RBITS-1:0])) * TICKS;
        run_attempt("after_reset", dt + 50, 0, 0);

        // Randomised attempts across early, lit and timeout outcomes.
        for (int i = 0; i < 8; i++) begin
            run_attempt($sformatf("rand%0d", i), int'($urandom_range(1, 580)), 0, 0);
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
